// File: rtl/cdb_arbiter.sv
// Common data bus driver: buffers functional-unit results in per-unit FIFOs and
// broadcasts one per cycle, chosen round-robin, through a registered CDB stage.
module cdb_arbiter #(
  parameter int NUM_FU     = 4,
  parameter int XLEN       = 32,
  parameter int TAG_W      = 6,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic [NUM_FU-1:0]         fu_valid,
  output logic [NUM_FU-1:0]         fu_ready,
  input  logic [NUM_FU*XLEN-1:0]    fu_result,
  input  logic [NUM_FU*TAG_W-1:0]   fu_tag,
  output logic                      cdb_valid,
  output logic [XLEN-1:0]           cdb_result,
  output logic [TAG_W-1:0]          cdb_tag,
  output logic [$clog2(NUM_FU)-1:0] cdb_fu_id,
  output logic [15:0]               conflict_cnt
);

  localparam int ID_W  = $clog2(NUM_FU);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = XLEN + TAG_W;

  logic [NUM_FU-1:0] req;
  logic [ENT_W-1:0]  head_entry [NUM_FU];
  logic              grant_valid;
  logic [ID_W-1:0]   grant_id;
  logic [ID_W-1:0]   scan_idx;
  logic [ENT_W-1:0]  grant_entry;
  logic              multi_req;
  logic [ID_W-1:0]   rr_ptr_reg;
  logic [ID_W-1:0]   rr_ptr_next;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_FU; gi++) begin : g_fifo
      logic [ENT_W-1:0] mem [FIFO_DEPTH];
      logic [PTR_W-1:0] wr_ptr_reg;
      logic [PTR_W-1:0] rd_ptr_reg;
      logic [CNT_W-1:0] count_reg;
      logic             push;
      logic             pop;

      // Ready depends only on the registered count, so a full FIFO refuses a
      // push even in a cycle where it is also being popped.
      assign fu_ready[gi]   = count_reg < CNT_W'(FIFO_DEPTH);
      assign req[gi]        = count_reg != '0;
      assign push           = fu_valid[gi] && fu_ready[gi];
      assign pop            = grant_valid && (grant_id == ID_W'(gi));
      assign head_entry[gi] = mem[rd_ptr_reg];

      always_ff @(posedge clk) begin
        if (push) begin
          mem[wr_ptr_reg] <= {fu_tag[gi*TAG_W +: TAG_W], fu_result[gi*XLEN +: XLEN]};
        end
      end

      always_ff @(posedge clk) begin
        if (rst || flush) begin
          wr_ptr_reg <= '0;
          rd_ptr_reg <= '0;
          count_reg  <= '0;
        end else begin
          if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
          if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
          case ({push, pop})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
          endcase
        end
      end
    end
  endgenerate

  // Scan from the highest offset down so the nearest requester after ptr wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = '0;
    scan_idx    = '0;
    for (int k = NUM_FU - 1; k >= 0; k--) begin
      scan_idx = ID_W'((int'(rr_ptr_reg) + k) % NUM_FU);
      if (req[scan_idx]) begin
        grant_valid = 1'b1;
        grant_id    = scan_idx;
      end
    end
  end

  assign grant_entry = head_entry[grant_id];
  assign multi_req   = |(req & (req - NUM_FU'(1)));
  assign rr_ptr_next = (int'(grant_id) == NUM_FU - 1) ? '0 : grant_id + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      cdb_valid    <= 1'b0;
      cdb_result   <= '0;
      cdb_tag      <= '0;
      cdb_fu_id    <= '0;
      conflict_cnt <= '0;
      rr_ptr_reg   <= '0;
    end else if (flush) begin
      cdb_valid <= 1'b0;
    end else begin
      cdb_valid <= grant_valid;
      if (grant_valid) begin
        cdb_result <= grant_entry[XLEN-1:0];
        cdb_tag    <= grant_entry[ENT_W-1:XLEN];
        cdb_fu_id  <= grant_id;
        rr_ptr_reg <= rr_ptr_next;
      end
      if (multi_req && (conflict_cnt != 16'hFFFF)) begin
        conflict_cnt <= conflict_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: one task per scenario with hand-computed expectations.
`timescale 1ns/1ps
module tb_cdb_arbiter;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         flush = 1'b0;
  logic [3:0]   fu_valid = 4'h0;
  logic [3:0]   fu_ready;
  logic [127:0] fu_result = '0;
  logic [23:0]  fu_tag = '0;
  logic         cdb_valid;
  logic [31:0]  cdb_result;
  logic [5:0]   cdb_tag;
  logic [1:0]   cdb_fu_id;
  logic [15:0]  conflict_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  cdb_arbiter #(.NUM_FU(4), .XLEN(32), .TAG_W(6), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .fu_valid(fu_valid), .fu_ready(fu_ready),
    .fu_result(fu_result), .fu_tag(fu_tag),
    .cdb_valid(cdb_valid), .cdb_result(cdb_result), .cdb_tag(cdb_tag),
    .cdb_fu_id(cdb_fu_id), .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (cdb_valid === 1'b1)
      $display("bcast fu=%0d tag=%h result=%h conflicts=%0d", cdb_fu_id, cdb_tag, cdb_result, conflict_cnt);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_fu(input int i, input logic [5:0] tag, input logic [31:0] res);
    fu_tag[i*6 +: 6]     = tag;
    fu_result[i*32 +: 32] = res;
  endtask

  task automatic do_reset;
    rst = 1'b1; flush = 1'b0; fu_valid = 4'h0;
    tick;
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; flush = 1'b1; fu_valid = 4'hF;
    for (int i = 0; i < 4; i++) set_fu(i, 6'h2A, 32'h1234_5678);
    tick;
    rst = 1'b0; flush = 1'b0; fu_valid = 4'h0;
    n_checks++; if (cdb_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", cdb_valid); end
    n_checks++; if (cdb_result !== 32'h0) begin n_fail++; $display("FAIL reset_result: got %h want 0", cdb_result); end
    n_checks++; if (cdb_tag !== 6'h0) begin n_fail++; $display("FAIL reset_tag: got %h want 0", cdb_tag); end
    n_checks++; if (cdb_fu_id !== 2'd0) begin n_fail++; $display("FAIL reset_fu_id: got %0d want 0", cdb_fu_id); end
    n_checks++; if (conflict_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_conflict: got %0d want 0", conflict_cnt); end
    n_checks++; if (fu_ready !== 4'hF) begin n_fail++; $display("FAIL reset_ready: got %b want 1111", fu_ready); end
    tick;
    n_checks++; if (cdb_valid !== 1'b0) begin n_fail++; $display("FAIL reset_no_push: got %b want 0", cdb_valid); end
  endtask

  task automatic test_single;
    do_reset;
    set_fu(2, 6'd17, 32'hDEAD_BEEF);
    fu_valid = 4'b0100;
    tick;
    fu_valid = 4'h0;
    n_checks++; if (cdb_valid !== 1'b0) begin n_fail++; $display("FAIL single_early: got %b want 0", cdb_valid); end
    n_checks++; if (fu_ready !== 4'hF) begin n_fail++; $display("FAIL single_ready0: got %b want 1111", fu_ready); end
    tick;
    n_checks++; if (cdb_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b want 1", cdb_valid); end
    n_checks++; if (cdb_tag !== 6'd17) begin n_fail++; $display("FAIL single_tag: got %0d want 17", cdb_tag); end
    n_checks++; if (cdb_result !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL single_result: got %h want deadbeef", cdb_result); end
    n_checks++; if (cdb_fu_id !== 2'd2) begin n_fail++; $display("FAIL single_fu_id: got %0d want 2", cdb_fu_id); end
    n_checks++; if (fu_ready !== 4'hF) begin n_fail++; $display("FAIL single_ready1: got %b want 1111", fu_ready); end
    tick;
    n_checks++; if (cdb_valid !== 1'b0) begin n_fail++; $display("FAIL single_pulse: got %b want 0", cdb_valid); end
  endtask

  task automatic test_all_push;
    do_reset;
    for (int i = 0; i < 4; i++) set_fu(i, 6'(i + 1), 32'hA000_0000 + 32'(i));
    fu_valid = 4'hF;
    tick;
    fu_valid = 4'h0;
    for (int k = 0; k < 4; k++) begin
      tick;
      n_checks++; if (cdb_valid !== 1'b1) begin n_fail++; $display("FAIL all_valid[%0d]: got %b want 1", k, cdb_valid); end
      n_checks++; if (cdb_fu_id !== 2'(k)) begin n_fail++; $display("FAIL all_fu_id[%0d]: got %0d want %0d", k, cdb_fu_id, k); end
      n_checks++; if (cdb_tag !== 6'(k + 1)) begin n_fail++; $display("FAIL all_tag[%0d]: got %0d want %0d", k, cdb_tag, k + 1); end
      n_checks++; if (cdb_result !== 32'hA000_0000 + 32'(k)) begin n_fail++; $display("FAIL all_result[%0d]: got %h want %h", k, cdb_result, 32'hA000_0000 + 32'(k)); end
    end
    tick;
    n_checks++; if (cdb_valid !== 1'b0) begin n_fail++; $display("FAIL all_idle: got %b want 0", cdb_valid); end
    n_checks++; if (conflict_cnt !== 16'd3) begin n_fail++; $display("FAIL all_conflict: got %0d want 3", conflict_cnt); end
  endtask

  task automatic test_fairness;
    int seq [3] = '{0, 1, 3};
    logic [5:0] tag_of [4] = '{6'd0, 6'd11, 6'd22, 6'd13};
    int last1 = 0;
    do_reset;
    set_fu(0, tag_of[0], 32'hF000_0000);
    set_fu(1, tag_of[1], 32'hF000_0001);
    set_fu(3, tag_of[3], 32'hF000_0003);
    fu_valid = 4'b1011;
    tick;
    for (int k = 0; k < 9; k++) begin
      tick;
      n_checks++; if (cdb_valid !== 1'b1) begin n_fail++; $display("FAIL fair_valid[%0d]: got %b want 1", k, cdb_valid); end
      n_checks++; if (cdb_fu_id !== 2'(seq[k % 3])) begin n_fail++; $display("FAIL fair_fu_id[%0d]: got %0d want %0d", k, cdb_fu_id, seq[k % 3]); end
      n_checks++; if (cdb_tag !== tag_of[seq[k % 3]]) begin n_fail++; $display("FAIL fair_tag[%0d]: got %0d want %0d", k, cdb_tag, tag_of[seq[k % 3]]); end
      if (cdb_valid === 1'b1 && cdb_fu_id === 2'd1) begin
        n_checks++; if (k - last1 > 3) begin n_fail++; $display("FAIL fair_wait1: got %0d want <=3", k - last1); end
        last1 = k;
      end
    end
    fu_valid = 4'h0;
  endtask

  task automatic test_backpressure;
    logic [5:0] exp0 [3] = '{6'h21, 6'h22, 6'h23};
    int sent = 0;
    int seen = 0;
    logic acc;
    do_reset;
    set_fu(1, 6'h31, 32'hB100_0000);
    set_fu(2, 6'h32, 32'hB200_0000);
    set_fu(3, 6'h33, 32'hB300_0000);
    fu_valid = 4'b1110;
    tick;
    set_fu(0, exp0[0], 32'hB000_0000);
    fu_valid[0] = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      acc = fu_valid[0] && fu_ready[0];
      tick;
      if (acc) begin
        sent++;
        if (sent < 3) set_fu(0, exp0[sent], 32'hB000_0000 + 32'(sent));
        else fu_valid[0] = 1'b0;
      end
      if (c == 1) begin n_checks++; if (fu_ready[0] !== 1'b1) begin n_fail++; $display("FAIL bp_ready_e1: got %b want 1", fu_ready[0]); end end
      if (c == 2) begin n_checks++; if (fu_ready[0] !== 1'b0) begin n_fail++; $display("FAIL bp_ready_e2: got %b want 0", fu_ready[0]); end end
      if (c == 3) begin n_checks++; if (fu_ready[0] !== 1'b0) begin n_fail++; $display("FAIL bp_ready_e3: got %b want 0", fu_ready[0]); end end
      if (c == 4) begin n_checks++; if (fu_ready[0] !== 1'b1) begin n_fail++; $display("FAIL bp_ready_e4: got %b want 1", fu_ready[0]); end end
      if (cdb_valid === 1'b1 && cdb_fu_id === 2'd0) begin
        n_checks++;
        if (seen >= 3) begin n_fail++; $display("FAIL bp_dup: got extra tag %h want none", cdb_tag); end
        else if (cdb_tag !== exp0[seen] || cdb_result !== 32'hB000_0000 + 32'(seen)) begin
          n_fail++; $display("FAIL bp_order[%0d]: got %h/%h want %h/%h", seen, cdb_tag, cdb_result, exp0[seen], 32'hB000_0000 + 32'(seen));
        end
        seen++;
      end
    end
    fu_valid = 4'h0;
    n_checks++; if (seen != 3) begin n_fail++; $display("FAIL bp_count: got %0d broadcasts want 3", seen); end
  endtask

  task automatic test_flush;
    do_reset;
    for (int i = 0; i < 4; i++) set_fu(i, 6'h20 + 6'(i), 32'hC000_0000 + 32'(i));
    fu_valid = 4'hF;
    tick;
    for (int i = 0; i < 3; i++) set_fu(i, 6'h28 + 6'(i), 32'hC100_0000 + 32'(i));
    fu_valid = 4'b0111;
    tick;
    n_checks++; if (cdb_valid !== 1'b1 || cdb_tag !== 6'h20) begin n_fail++; $display("FAIL flush_pre: got %b/%h want 1/20", cdb_valid, cdb_tag); end
    flush = 1'b1;
    fu_valid = 4'b1000;
    set_fu(3, 6'h3F, 32'hDEAD_0003);
    tick;
    flush = 1'b0;
    fu_valid = 4'h0;
    n_checks++; if (cdb_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %b want 0", cdb_valid); end
    n_checks++; if (cdb_tag !== 6'h20) begin n_fail++; $display("FAIL flush_tag_hold: got %h want 20", cdb_tag); end
    n_checks++; if (fu_ready !== 4'hF) begin n_fail++; $display("FAIL flush_ready: got %b want 1111", fu_ready); end
    n_checks++; if (conflict_cnt !== 16'd1) begin n_fail++; $display("FAIL flush_conflict: got %0d want 1", conflict_cnt); end
    for (int k = 0; k < 3; k++) begin
      tick;
      n_checks++; if (cdb_valid !== 1'b0) begin n_fail++; $display("FAIL flush_quiet[%0d]: got %b want 0", k, cdb_valid); end
    end
    set_fu(0, 6'h01, 32'hE000_0000);
    set_fu(3, 6'h03, 32'hE000_0003);
    fu_valid = 4'b1001;
    tick;
    fu_valid = 4'h0;
    tick;
    n_checks++; if (cdb_valid !== 1'b1 || cdb_fu_id !== 2'd3 || cdb_tag !== 6'h03) begin n_fail++; $display("FAIL flush_ptr_first: got %b/%0d/%h want 1/3/03", cdb_valid, cdb_fu_id, cdb_tag); end
    tick;
    n_checks++; if (cdb_valid !== 1'b1 || cdb_fu_id !== 2'd0 || cdb_tag !== 6'h01) begin n_fail++; $display("FAIL flush_ptr_second: got %b/%0d/%h want 1/0/01", cdb_valid, cdb_fu_id, cdb_tag); end
    n_checks++; if (conflict_cnt !== 16'd2) begin n_fail++; $display("FAIL flush_conflict_after: got %0d want 2", conflict_cnt); end
  endtask

  task automatic test_reset_mid;
    do_reset;
    for (int i = 0; i < 4; i++) set_fu(i, 6'h30 + 6'(i), 32'h7000_0000 + 32'(i));
    fu_valid = 4'hF;
    tick;
    fu_valid = 4'h0;
    tick;
    tick;
    rst = 1'b1; flush = 1'b1; fu_valid = 4'hF;
    tick;
    rst = 1'b0; flush = 1'b0; fu_valid = 4'h0;
    n_checks++; if (cdb_valid !== 1'b0) begin n_fail++; $display("FAIL mid_valid: got %b want 0", cdb_valid); end
    n_checks++; if (cdb_result !== 32'h0 || cdb_tag !== 6'h0) begin n_fail++; $display("FAIL mid_data: got %h/%h want 0/0", cdb_result, cdb_tag); end
    n_checks++; if (cdb_fu_id !== 2'd0) begin n_fail++; $display("FAIL mid_fu_id: got %0d want 0", cdb_fu_id); end
    n_checks++; if (conflict_cnt !== 16'd0) begin n_fail++; $display("FAIL mid_conflict: got %0d want 0", conflict_cnt); end
    n_checks++; if (fu_ready !== 4'hF) begin n_fail++; $display("FAIL mid_ready: got %b want 1111", fu_ready); end
    set_fu(1, 6'h11, 32'h9000_0001);
    set_fu(3, 6'h13, 32'h9000_0003);
    fu_valid = 4'b1010;
    tick;
    fu_valid = 4'h0;
    tick;
    n_checks++; if (cdb_valid !== 1'b1 || cdb_fu_id !== 2'd1 || cdb_tag !== 6'h11) begin n_fail++; $display("FAIL mid_first: got %b/%0d/%h want 1/1/11", cdb_valid, cdb_fu_id, cdb_tag); end
    tick;
    n_checks++; if (cdb_valid !== 1'b1 || cdb_fu_id !== 2'd3 || cdb_tag !== 6'h13) begin n_fail++; $display("FAIL mid_second: got %b/%0d/%h want 1/3/13", cdb_valid, cdb_fu_id, cdb_tag); end
    tick;
    n_checks++; if (cdb_valid !== 1'b0) begin n_fail++; $display("FAIL mid_idle: got %b want 0", cdb_valid); end
  endtask

  initial begin
    test_reset;
    test_single;
    test_all_push;
    test_fairness;
    test_backpressure;
    test_flush;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Driving end of the common data bus (CDB).
- Collects completed results from NUM_FU functional units, buffers each in a small per-unit FIFO, and grants one result per cycle round-robin.
- Broadcasts the granted result on a registered CDB: result, physical register tag and valid.
- Consumers are the reservation stations, the forwarding logic and the physical register file write port.

Parameters:
- NUM_FU, 4, number of functional-unit result ports (2..8).
- XLEN, 32, result width.
- TAG_W, 6, physical register tag width (64 physical regs).
- FIFO_DEPTH, 2, entries per FU buffer (power of 2, ≥2).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  misprediction/exception squash; drops all buffered and in-flight results.
- fu_valid  input  NUM_FU  per-FU result valid.
- fu_ready  output  NUM_FU  per-FU buffer can accept.
- fu_result  input  NUM_FU*XLEN  packed results; FU i at bits [i*XLEN +: XLEN].
- fu_tag  input  NUM_FU*TAG_W  packed destination physical tags.
- cdb_valid  output  1  broadcast valid.
- cdb_result  output  XLEN  broadcast value.
- cdb_tag  output  TAG_W  broadcast physical tag.
- cdb_fu_id  output  $clog2(NUM_FU)  index of the FU that produced the broadcast.
- conflict_cnt  output  16  saturating count of cycles with ≥2 FIFOs non-empty.

Behaviour:
- Reset (rst high at edge):
  - All FIFOs empty; round-robin pointer = 0.
  - cdb_valid=0, cdb_result=0, cdb_tag=0, cdb_fu_id=0, conflict_cnt=0.
  - fu_ready = all ones from the first cycle after reset.
  - rst overrides flush and pushes.
- Handshake:
  - Transfer for FU i occurs when fu_valid[i] && fu_ready[i] at an edge.
  - fu_ready[i] = (count[i] < FIFO_DEPTH), from registered count only, with no combinational path from fu_valid or the grant.
  - A full FIFO therefore refuses a push even if it is being popped the same cycle.
  - fu_valid while not ready is ignored: no state change, and the FU must hold its data.
- FIFO:
  - Per-FU circular buffer with read/write pointers that wrap modulo FIFO_DEPTH.
  - Count range is 0..FIFO_DEPTH.
  - Simultaneous push and pop on a non-full FIFO leaves the count unchanged.
- Arbitration (combinational, over registered FIFO heads):
  - Request[i] = count[i] != 0.
  - Grant = first requesting index scanning ptr, ptr+1, …, wrapping at NUM_FU.
  - On grant g: pop FIFO g; ptr ← (g+1) mod NUM_FU.
  - With no requests, ptr holds.
- Output register, loaded every edge:
  - cdb_valid ← any request.
  - cdb_result/cdb_tag/cdb_fu_id ← head of granted FIFO.
  - When there is no grant, cdb_valid=0 and the data fields hold their previous values.
- Latency: a result accepted at edge E0 is broadcast at the earliest in the cycle following edge E1 = E0+1. Minimum accept-to-visible latency is 2 edges.
- Throughput: one broadcast per cycle sustained. A single FU streaming alone gets every cycle.
- Fairness: with all FUs continuously requesting, grants cycle 0,1,…,NUM_FU-1 and each FU waits at most NUM_FU-1 cycles.
- Flush (flush high at edge, rst low):
  - All FIFOs emptied; cdb_valid ← 0 at that edge.
  - Pushes in the same cycle are dropped.
  - ptr and conflict_cnt hold.
- Counter: conflict_cnt increments when ≥2 requests exist and saturates at 16'hFFFF.
- Tag value 0 is a legal tag and is broadcast normally; no special casing.

Test Plan:
- Reset release then FU2 pushes tag=6'd17, result=32'hDEAD_BEEF at edge E0 -> cdb_valid=1 with tag 17, value DEADBEEF, fu_id=2 in the cycle after E0+1; single pulse; fu_ready stays 4'b1111.
- All 4 FUs push one result each in the same cycle (tags 1,2,3,4) -> four consecutive broadcasts in order fu_id 0,1,2,3; conflict_cnt=3 afterwards.
- FU1 holds fu_valid continuously while FU0 and FU3 also stream -> grants rotate 0,1,3,0,1,3…; FU1 never waits more than 3 cycles.
- FU0 pushes 3 back-to-back results while FU1–3 keep FIFOs non-empty -> fu_ready[0] drops to 0 after 2 accepts; the third is accepted only after the FIFO drains; no result lost or duplicated; tags broadcast in push order.
- Load 2 entries in every FIFO, assert flush with a simultaneous FU3 push -> cdb_valid=0 next cycle and stays 0; all fu_ready=1; the FU3 push does not appear; ptr unchanged.
- Assert rst mid-stream with FIFOs partially full and flush=1 -> all outputs at reset values next cycle; the next single push from FU1 is granted first (ptr=0 scan).
